// File: rtl/se_tick_gen.sv
// se_tick_gen: multi-channel programmable divider / tick generator.
// Each channel counts enabled cycles up to its divisor. At the terminal count
// it emits a one-cycle tick and toggles a 50% square wave. New divisors are
// loaded into a shadow register and take effect only when the counter
// restarts, so the current period is never shortened or stretched.
module se_tick_gen #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 27,
  parameter int RESET_DIV = 4999,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] clr,
  input  logic              load,
  input  logic [SEL_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_val,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);

  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_d     [NUM_CH];
  logic [CNT_W-1:0]  div_cur_q [NUM_CH];
  logic [CNT_W-1:0]  div_cur_d [NUM_CH];
  logic [CNT_W-1:0]  div_nxt_q [NUM_CH];
  logic [CNT_W-1:0]  div_nxt_d [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] div_clk_q, div_clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] load_hit_s;
  logic [NUM_CH-1:0] term_s;

  // Decode the load target and the per-channel terminal count.
  // An out-of-range load_ch matches no channel and is therefore ignored.
  always_comb begin
    load_hit_s = '0;
    term_s     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load_hit_s[i] = load && (load_ch == SEL_W'(i));
      term_s[i]     = en[i] && (cnt_q[i] == div_cur_q[i]);
    end
  end

  // Next-state logic: clr beats terminal count, which beats plain counting.
  // The divisor is swapped only when the counter restarts (clr or terminal).
  always_comb begin
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    pending_d = pending_q;
    div_clk_d = div_clk_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr[i]) begin
        cnt_d[i]     = '0;
        div_clk_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
      end else if (term_s[i]) begin
        cnt_d[i]     = '0;
        div_clk_d[i] = ~div_clk_q[i];
        tick_d[i]    = 1'b1;
      end else if (en[i]) begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        tick_d[i] = 1'b0;
      end else begin
        tick_d[i] = 1'b0;
      end

      if (clr[i] || term_s[i]) begin
        // A load arriving on the restart cycle bypasses the shadow register.
        if (load_hit_s[i]) begin
          div_cur_d[i] = load_val;
          div_nxt_d[i] = load_val;
          pending_d[i] = 1'b0;
        end else if (pending_q[i]) begin
          div_cur_d[i] = div_nxt_q[i];
          pending_d[i] = 1'b0;
        end else begin
          pending_d[i] = 1'b0;
        end
      end else if (load_hit_s[i]) begin
        // Last load wins while waiting for the next restart.
        div_nxt_d[i] = load_val;
        pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= '0;
        div_cur_q[i] <= RST_DIV;
        div_nxt_q[i] <= RST_DIV;
      end
      pending_q <= '0;
      div_clk_q <= '0;
      tick_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      div_nxt_q <= div_nxt_d;
      pending_q <= pending_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
    end
  end

  assign div_clk = div_clk_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule
